// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared defaults and range helpers for the pipelined multiply-accumulate block.
//   DEF_DATA_W / DEF_ACC_W / DEF_VEC_LEN : default parameter values
//   umax_of(w) : largest unsigned value of a w-bit word
//   smax_of(w) : largest two's-complement value of a w-bit word
//   smin_of(w) : smallest two's-complement value of a w-bit word
// All helpers return 64-bit words (w <= 64); callers keep the low w bits.
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_VEC_LEN = 4;

    function automatic logic [63:0] umax_of(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] smax_of(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // The low w bits of ~smax are 1000...0, i.e. the most negative value.
    function automatic logic [63:0] smin_of(input int w);
        return ~smax_of(w);
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// -----------------------------------------------------------------------------
// mac_mult_stage
// Stage 1 of the MAC: extends both operands according to the vector's
// signedness, multiplies them and registers the product (sign- or zero-
// extended to ACC_W) together with the beat's last-of-vector flag.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : synchronous abort, drops the registered beat
//   accept        : a beat is taken on this edge
//   signed_mode   : signedness for this beat (already latched per vector)
//   last          : this beat closes the vector
//   a, b          : operands
//   p_valid       : stage holds a product
//   p_last        : held product is the last beat of its vector
//   p_signed      : signedness the held product was formed with
//   p_data        : product extended to ACC_W
// -----------------------------------------------------------------------------
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              accept,
    input  logic              signed_mode,
    input  logic              last,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              p_valid,
    output logic              p_last,
    output logic              p_signed,
    output logic [ACC_W-1:0]  p_data
);

    // Multiply in a width that holds the full product of two (DATA_W+1)-bit
    // signed operands and also spans ACC_W, so the low ACC_W bits are the
    // correctly extended product in either mode.
    localparam int PW = (ACC_W > 2*DATA_W + 2) ? ACC_W : 2*DATA_W + 2;

    logic signed [DATA_W:0] a_ext;
    logic signed [DATA_W:0] b_ext;
    logic signed [PW-1:0]   prod;

    always_comb begin
        a_ext = $signed({signed_mode & a[DATA_W-1], a});
        b_ext = $signed({signed_mode & b[DATA_W-1], b});
        prod  = $signed(PW'(a_ext)) * $signed(PW'(b_ext));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid  <= 1'b0;
            p_last   <= 1'b0;
            p_signed <= 1'b0;
            p_data   <= '0;
        end else if (clr) begin
            // clr beats a simultaneous accept: the beat is discarded.
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_valid <= accept;
            p_last  <= accept & last;
            if (accept) begin
                p_signed <= signed_mode;
                p_data   <= prod[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pipelined_mac.sv
// -----------------------------------------------------------------------------
// pipelined_mac
// Two-stage multiply-accumulate over vectors of VEC_LEN beats.
// Stage 1 (mac_mult_stage) registers the product of an accepted beat; stage 2
// adds it to the accumulator and, on the vector's last beat, presents the
// final sum on the result handshake and reloads the accumulator with zero.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   clr                 : synchronous abort of the vector in progress
//   signed_mode         : 1 = two's-complement operands (latched per vector)
//   in_valid/in_ready   : operand handshake, operands a and b
//   out_valid/out_ready : result handshake, out_data and out_ovf
// Build option:
//   MAC_SATURATE_EN     : when defined, an overflowing addition clamps the
//                         accumulator to the ACC_W limit and it stays there
//                         for the rest of the vector; otherwise it wraps.
// -----------------------------------------------------------------------------
module pipelined_mac
    import mac_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int VEC_LEN = DEF_VEC_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              signed_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

`ifdef MAC_SATURATE_EN
    localparam logic [63:0] UMAX64 = umax_of(ACC_W);
    localparam logic [63:0] SMAX64 = smax_of(ACC_W);
    localparam logic [63:0] SMIN64 = smin_of(ACC_W);
    localparam logic [ACC_W-1:0] UMAX = UMAX64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SMAX = SMAX64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SMIN = SMIN64[ACC_W-1:0];
`endif

    logic [CNT_W-1:0] cnt_reg;
    logic             mode_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             ovf_reg;

    logic             accept;
    logic             last_beat;
    logic             mode_eff;
    logic             p_valid;
    logic             p_last;
    logic             p_signed;
    logic [ACC_W-1:0] p_data;

    logic [ACC_W:0]   usum;
    logic [ACC_W-1:0] sum;
    logic             ovf_now;
    logic [ACC_W-1:0] acc_next;

    // One bubble per vector: while stage 1 holds a last beat the next beat
    // waits, so a new vector never starts adding into a result being emitted.
    assign in_ready  = !((out_valid && !out_ready) || (p_valid && p_last));
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_reg == LAST_CNT);
    // The first beat of a vector uses the live signed_mode; later beats use
    // the value captured on that first beat.
    assign mode_eff  = (cnt_reg == '0) ? signed_mode : mode_reg;

    mac_mult_stage #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mult (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .accept      (accept),
        .signed_mode (mode_eff),
        .last        (last_beat),
        .a           (a),
        .b           (b),
        .p_valid     (p_valid),
        .p_last      (p_last),
        .p_signed    (p_signed),
        .p_data      (p_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            mode_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= last_beat ? '0 : cnt_reg + CNT_W'(1);
            if (cnt_reg == '0) begin
                mode_reg <= signed_mode;
            end
        end
    end

    // Stage 2 adder. Unsigned overflow is the carry out; signed overflow is
    // two same-sign addends giving a result of the other sign.
    always_comb begin
        usum = {1'b0, acc_reg} + {1'b0, p_data};
        sum  = usum[ACC_W-1:0];
        if (p_signed) begin
            ovf_now = (acc_reg[ACC_W-1] == p_data[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_reg[ACC_W-1]);
        end else begin
            ovf_now = usum[ACC_W];
        end
`ifdef MAC_SATURATE_EN
        if (ovf_reg) begin
            acc_next = acc_reg;
        end else if (ovf_now) begin
            if (!p_signed) begin
                acc_next = UMAX;
            end else begin
                acc_next = acc_reg[ACC_W-1] ? SMIN : SMAX;
            end
        end else begin
            acc_next = sum;
        end
`else
        acc_next = sum;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            // Consumed results drop; a result loading on the same edge wins.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clr) begin
                acc_reg <= '0;
                ovf_reg <= 1'b0;
            end else if (p_valid) begin
                if (p_last) begin
                    acc_reg   <= '0;
                    ovf_reg   <= 1'b0;
                    out_valid <= 1'b1;
                    out_data  <= acc_next;
                    out_ovf   <= ovf_reg | ovf_now;
                end else begin
                    acc_reg <= acc_next;
                    ovf_reg <= ovf_reg | ovf_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_mac.sv
// -----------------------------------------------------------------------------
// tb_pipelined_mac
// Self-checking bench for pipelined_mac: directed vectors with known results,
// then randomized traffic scored against an arithmetic reference model.
// A second instance with VEC_LEN=300 exercises accumulator overflow.
// -----------------------------------------------------------------------------
module tb_pipelined_mac;

    localparam int DW     = 8;
    localparam int AW     = 24;
    localparam int VL     = 4;
    localparam int BIG_VL = 300;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          signed_mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ovf;
    logic [AW-1:0] out_data;

    logic          b_clr = 1'b0;
    logic          b_mode = 1'b0;
    logic          b_in_valid = 1'b0;
    logic          b_out_ready = 1'b1;
    logic [DW-1:0] b_a = 8'hFF;
    logic [DW-1:0] b_b = 8'hFF;
    logic          b_in_ready;
    logic          b_out_valid;
    logic          b_out_ovf;
    logic [AW-1:0] b_out_data;

    always #5 clk = ~clk;

    pipelined_mac #(.DATA_W(DW), .ACC_W(AW), .VEC_LEN(VL)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    pipelined_mac #(.DATA_W(DW), .ACC_W(AW), .VEC_LEN(BIG_VL)) u_big (
        .clk(clk), .rst(rst), .clr(b_clr), .signed_mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .a(b_a), .b(b_b),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ovf(b_out_ovf)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: exact integer running sum of the current vector.
    longint        m_acc = 0;
    bit            m_ovf = 0;
    bit            m_mode = 0;
    int            m_cnt = 0;
    bit            vec_done = 0;
    bit            hold_last = 0;
    logic [AW-1:0] exp_d[$];
    bit            exp_o[$];
    logic [AW-1:0] out_log[$];
    bit            last_acc = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_ovf = 0;
        m_cnt = 0;
    endtask

    task automatic model_beat(logic [DW-1:0] ai, logic [DW-1:0] bi, bit sm);
        longint p, sum, lo, hi, span;
        if (m_cnt == 0) m_mode = sm;
        if (m_mode) p = longint'($signed(ai)) * longint'($signed(bi));
        else        p = longint'(ai) * longint'(bi);
        span = longint'(1) << AW;
        lo   = m_mode ? -(span / 2) : 0;
        hi   = m_mode ? (span / 2 - 1) : (span - 1);
        sum  = m_acc + p;
`ifdef MAC_SATURATE_EN
        if (m_ovf) sum = m_acc;
        else if (sum > hi) begin sum = hi; m_ovf = 1; end
        else if (sum < lo) begin sum = lo; m_ovf = 1; end
`else
        if (sum > hi || sum < lo) m_ovf = 1;
        sum = ((sum % span) + span) % span;
        if (m_mode && sum > hi) sum = sum - span;
`endif
        m_acc = sum;
        m_cnt++;
        if (m_cnt == VL) begin
            exp_d.push_back(AW'(m_acc));
            exp_o.push_back(m_ovf);
            vec_done = 1;
            model_clear();
        end
    endtask

    // One clock: entered at a negedge with inputs already driven, samples
    // the handshakes, scores any result taken, updates the model and
    // returns at the next negedge.
    task automatic cycle();
        bit exp_rdy;
        #1;
        exp_rdy = !((out_valid && !out_ready) || hold_last);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            check("out_pending", 64'(exp_d.size() > 0), 64'(1));
            if (exp_d.size() > 0) begin
                check("out_data", 64'(out_data), 64'(exp_d[0]));
                check("out_ovf", 64'(out_ovf), 64'(exp_o[0]));
                void'(exp_d.pop_front());
                void'(exp_o.pop_front());
            end
        end
        vec_done = 0;
        if (clr) model_clear();
        else if (last_acc) model_beat(a, b, signed_mode);
        hold_last = !clr && last_acc && vec_done;
        @(negedge clk);
    endtask

    task automatic send(logic [DW-1:0] ai, logic [DW-1:0] bi, bit sm);
        a = ai;
        b = bi;
        signed_mode = sm;
        in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            cycle();
            if (last_acc) break;
        end
        check("send_accept", 64'(last_acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    // Asserts rst between edges; outputs must clear without waiting for clk.
    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_ovf", 64'(out_ovf), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        exp_d.delete();
        exp_o.delete();
        hold_last = 0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int bacc;
        bit bdone;
        logic [AW-1:0] bdata;
        logic          bovf;

        @(negedge clk);
        do_reset();

        // Unsigned 3*4 x4, with latency and bubble checks.
        out_ready = 1'b1;
        repeat (4) send(8'd3, 8'd4, 1'b0);
        check("lat_early", 64'(out_valid), 64'(0));
        check("bubble", 64'(in_ready), 64'(0));
        idle(1);
        check("lat_out_valid", 64'(out_valid), 64'(1));
        check("r028_data", 64'(out_data), 64'(48));
        check("r028_ovf", 64'(out_ovf), 64'(0));
        idle(2);

        // Signed vs unsigned interpretation of the same bits.
        repeat (4) send(8'hFE, 8'd5, 1'b1);
        idle(3);
        check("r029_signed", 64'(out_log[$]), 64'(24'hFFFFD8));
        repeat (4) send(8'hFE, 8'd5, 1'b0);
        idle(3);
        check("r029_unsigned", 64'(out_log[$]), 64'(5080));

        // signed_mode changes mid-vector must not affect that vector.
        send(8'hFE, 8'd5, 1'b1);
        repeat (3) send(8'hFE, 8'd5, 1'b0);
        idle(3);
        check("mode_latch", 64'(out_log[$]), 64'(24'hFFFFD8));

        // Back-pressure: result held, no beat taken, order preserved.
        out_ready = 1'b0;
        n0 = out_log.size();
        repeat (4) send(8'd1, 8'd2, 1'b0);
        idle(1);
        a = 8'd2;
        b = 8'd3;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_data", 64'(out_data), 64'(8));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) send(8'd2, 8'd3, 1'b0);
        idle(3);
        check("r031_count", 64'(out_log.size() - n0), 64'(2));
        if (out_log.size() >= n0 + 2) begin
            check("r031_first", 64'(out_log[n0]), 64'(8));
            check("r031_second", 64'(out_log[n0+1]), 64'(24));
        end

        // clr mid-vector with a beat offered on the same edge.
        send(8'd7, 8'd9, 1'b0);
        send(8'd7, 8'd9, 1'b0);
        a = 8'd7;
        b = 8'd9;
        in_valid = 1'b1;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        in_valid = 1'b0;
        repeat (4) send(8'd1, 8'd1, 1'b0);
        idle(3);
        check("r032_data", 64'(out_log[$]), 64'(4));

        // Reset with a pending result, then reset mid-vector.
        out_ready = 1'b0;
        repeat (4) send(8'd1, 8'd2, 1'b0);
        idle(2);
        check("r033_pending", 64'(out_valid), 64'(1));
        do_reset();
        out_ready = 1'b1;
        send(8'd9, 8'd9, 1'b0);
        send(8'd9, 8'd9, 1'b0);
        do_reset();
        repeat (4) send(8'd2, 8'd2, 1'b0);
        idle(3);
        check("r033_fresh", 64'(out_log[$]), 64'(16));

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            signed_mode = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr = !hold_last && ($urandom_range(0, 15) == 0);
            cycle();
        end
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) cycle();
        check("drain_empty", 64'(exp_d.size()), 64'(0));

        // 300 beats of 255*255 unsigned overflow a 24-bit accumulator.
        bacc = 0;
        bdone = 0;
        bdata = '0;
        bovf = 1'b0;
        b_in_valid = 1'b1;
        for (int t = 0; t < 400 && !bdone; t++) begin
            #1;
            if (b_in_valid && b_in_ready) bacc++;
            if (b_out_valid) begin
                bdone = 1;
                bdata = b_out_data;
                bovf = b_out_ovf;
            end
            @(negedge clk);
            if (bacc >= BIG_VL) b_in_valid = 1'b0;
        end
        check("r030_done", 64'(bdone), 64'(1));
        check("r030_beats", 64'(bacc), 64'(BIG_VL));
        check("r030_ovf", 64'(bovf), 64'(1));
`ifdef MAC_SATURATE_EN
        check("r030_data", 64'(bdata), 64'(24'hFFFFFF));
`else
        check("r030_data", 64'(bdata), 64'(2730284));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
